// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, defaults,
// and the {instr, pc} packet carried through the IF/ID register.
package fetch_unit_pkg;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID output register with a one-entry skid buffer; the skid absorbs the
// single response that may land while decode is stalled.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  fetch_pkt_t  in_pkt,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    fetch_pkt_t skid;
    logic       skid_valid;

    assign id_pc_plus4 = id_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'h0;
            skid       <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (in_valid) begin
            if (!id_valid || id_ready) begin
                id_valid <= 1'b1;
                id_instr <= in_pkt.instr;
                id_pc    <= in_pkt.pc;
            end else begin
                skid       <= in_pkt;
                skid_valid <= 1'b1;
            end
        end else if (id_valid && id_ready) begin
            // A new load and a skid drain never coincide: the FSM only
            // waits on memory once the skid is empty.
            if (skid_valid) begin
                id_instr   <= skid.instr;
                id_pc      <= skid.pc;
                skid_valid <= 1'b0;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding imem reads and
// feeds decode through the IF/ID register; execute redirects kill in-flight reads.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic        kill;
    logic        req_acc;
    logic        outstanding;
    logic        load_valid;
    fetch_pkt_t  load_pkt;

    // Request is masked while reset is held so nothing escapes before release.
    assign imem_req_valid = rst_n && (state == ST_REQ);
    assign imem_addr      = pc;
    assign req_acc        = imem_req_valid && imem_req_ready;

    // A response arriving this cycle retires the read, so a redirect then
    // has nothing left to kill.
    assign outstanding = req_acc || ((state == ST_WAIT) && !imem_rsp_valid);
    assign load_valid  = (state == ST_WAIT) && imem_rsp_valid && !kill && !redirect_valid;
    assign load_pkt    = '{instr: imem_rsp_data, pc: pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= align_pc(redirect_pc);
            kill  <= outstanding;
            state <= outstanding ? ST_WAIT : ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_acc) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= (!id_valid || id_ready) ? ST_REQ : ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (id_ready) state <= ST_REQ;
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .in_valid    (load_valid),
        .in_pkt      (load_pkt),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency,
// transfer monitor, and hand-computed expected fetch/decode streams.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] acc_q[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_ins[$];
    logic [31:0] dlv_p4[$];

    int          rsp_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_paddr = 32'h0;
    logic        mem_acc;
    logic [31:0] mem_a;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h0050_0093 : ~a;
    endfunction

    // Memory: response visible rsp_lat cycles after accept, oblivious to reset.
    always @(posedge clk) begin
        mem_acc = imem_req_valid && imem_req_ready;
        mem_a   = imem_addr;
        if (mem_acc) acc_q.push_back(mem_a);
        #1;
        imem_rsp_valid = 1'b0;
        if (mem_acc) begin
            mem_paddr = mem_a;
            mem_cnt   = rsp_lat;
        end
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_paddr);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            dlv_pc.push_back(id_pc);
            dlv_ins.push_back(id_instr);
            dlv_p4.push_back(id_pc_plus4);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_acc(input int n);
        int b = 0;
        while (acc_q.size() < n && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk("wait_acc", 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_dlv(input int n);
        int b = 0;
        while (dlv_pc.size() < n && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk("wait_dlv", 32'(dlv_pc.size() >= n), 32'd1);
    endtask

    // Leaves rst_n low at a falling edge with queues cleared; caller releases.
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_lat        = 1;
        repeat (5) @(negedge clk);
        chk("rst id_valid", 32'(id_valid), 32'd0);
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst id_instr", id_instr, 32'h0000_0013);
        chk("rst id_pc", id_pc, 32'h0);
        chk("rst id_pc_plus4", id_pc_plus4, 32'h4);
        acc_q.delete();
        dlv_pc.delete();
        dlv_ins.delete();
        dlv_p4.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat;

        // 1: streaming fetch, one instruction every two cycles
        @(negedge clk);
        do_reset();
        imem_req_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = id_valid;
        end
        chk("t1 id_valid pattern", 32'(pat), 32'(6'b101010));
        wait_dlv(3);
        chk("t1 addr0", acc_q[0], 32'h0);
        chk("t1 addr1", acc_q[1], 32'h4);
        chk("t1 addr2", acc_q[2], 32'h8);
        chk("t1 pc0", dlv_pc[0], 32'h0);
        chk("t1 pc1", dlv_pc[1], 32'h4);
        chk("t1 pc2", dlv_pc[2], 32'h8);
        chk("t1 p4_0", dlv_p4[0], 32'h4);
        chk("t1 p4_2", dlv_p4[2], 32'hC);
        chk("t1 ins0", dlv_ins[0], 32'hFFFF_FFFF);
        chk("t1 ins1", dlv_ins[1], 32'h0050_0093);
        chk("t1 ins2", dlv_ins[2], 32'hFFFF_FFF7);

        // 2: decode stalled, second word parks in the skid
        do_reset();
        imem_req_ready = 1'b1;
        id_ready = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t2 req count", 32'(acc_q.size()), 32'd2);
        chk("t2 no req in hold", 32'(imem_req_valid), 32'd0);
        chk("t2 id_valid held", 32'(id_valid), 32'd1);
        chk("t2 id_pc held", id_pc, 32'h0);
        chk("t2 id_instr held", id_instr, 32'hFFFF_FFFF);
        id_ready = 1'b1;
        wait_dlv(3);
        chk("t2 pc0", dlv_pc[0], 32'h0);
        chk("t2 pc1", dlv_pc[1], 32'h4);
        chk("t2 ins1", dlv_ins[1], 32'h0050_0093);
        chk("t2 pc2", dlv_pc[2], 32'h8);
        chk("t2 addr2", acc_q[2], 32'h8);

        // 3: redirect while waiting on addr 0x8
        do_reset();
        rsp_lat = 3;
        imem_req_ready = 1'b1;
        rst_n = 1'b1;
        wait_acc(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_dlv(3);
        chk("t3 addr2", acc_q[2], 32'h8);
        chk("t3 addr3", acc_q[3], 32'h100);
        chk("t3 pc1", dlv_pc[1], 32'h4);
        chk("t3 pc2", dlv_pc[2], 32'h100);
        chk("t3 ins2", dlv_ins[2], 32'hFFFF_FEFF);

        // 4: redirect coincident with request accept, unaligned target
        do_reset();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        rst_n = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_dlv(2);
        chk("t4 addr0", acc_q[0], 32'h0);
        chk("t4 addr1", acc_q[1], 32'h200);
        chk("t4 pc0", dlv_pc[0], 32'h200);
        chk("t4 ins0", dlv_ins[0], 32'hFFFF_FDFF);
        chk("t4 pc1", dlv_pc[1], 32'h204);

        // 5: PC wrap from the top of the address space
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        rst_n = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_dlv(2);
        chk("t5 addr0", acc_q[0], 32'hFFFF_FFFC);
        chk("t5 addr1", acc_q[1], 32'h0);
        chk("t5 pc0", dlv_pc[0], 32'hFFFF_FFFC);
        chk("t5 p4_0", dlv_p4[0], 32'h0);
        chk("t5 ins0", dlv_ins[0], 32'h3);
        chk("t5 pc1", dlv_pc[1], 32'h0);
        chk("t5 p4_1", dlv_p4[1], 32'h4);

        // 6: reset during WAIT, stale response lands after release
        do_reset();
        rsp_lat = 3;
        imem_req_ready = 1'b1;
        rst_n = 1'b1;
        wait_acc(1);
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("t6 id_valid in rst", 32'(id_valid), 32'd0);
        chk("t6 req_valid in rst", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 stale rsp ignored", 32'(id_valid), 32'd0);
        chk("t6 req after rst", 32'(imem_req_valid), 32'd1);
        chk("t6 addr after rst", imem_addr, 32'h0);
        rsp_lat = 1;
        imem_req_ready = 1'b1;
        wait_dlv(1);
        chk("t6 refetch addr", acc_q[1], 32'h0);
        chk("t6 pc0", dlv_pc[0], 32'h0);
        chk("t6 ins0", dlv_ins[0], 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
